// File: rtl/mbf_decim_fifo.sv
// Decimate-by-2 stage for the multi-bank filter's paired band outputs,
// feeding a first-word-fall-through FIFO with a sticky overflow flag.
module mbf_decim_fifo #(
    parameter int unsigned DW    = 13,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    input  logic [DW-1:0]     X_IN,
    input  logic [DW-1:0]     Y_IN,
    input  logic              OUT_READY,
    output logic              OUT_VALID,
    output logic [2*DW-1:0]   OUT_DATA,
    output logic [AW:0]       COUNT,
    output logic              OVERFLOW
);

    localparam int unsigned WW = 2 * DW;
    localparam int unsigned CW = AW + 1;

    logic [WW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          phase;

    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_next;
    logic          phase_next;
    logic [WW-1:0] head_next;
    logic [WW-1:0] din;
    logic          keep;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    // Keep/push/pop decisions and the next head word, all from registered state
    always_comb begin
        din         = {X_IN, Y_IN};
        keep        = IN_VALID && !phase;
        full        = (COUNT == CW'(DEPTH));
        pop         = OUT_VALID && OUT_READY;
        push        = keep && (!full || pop);
        drop        = keep && full && !pop;
        phase_next  = IN_VALID ? !phase : 1'b0;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = COUNT;
        head_next   = '0;

        if (push) begin
            wr_ptr_next = AW'(wr_ptr + 1'b1);
        end
        if (pop) begin
            rd_ptr_next = AW'(rd_ptr + 1'b1);
        end
        if (push && !pop) begin
            count_next = CW'(COUNT + 1'b1);
        end else if (pop && !push) begin
            count_next = CW'(COUNT - 1'b1);
        end

        // The new head is the word being written now when the read pointer lands on it
        if (count_next != '0) begin
            if (push && (rd_ptr_next == wr_ptr)) begin
                head_next = din;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            COUNT     <= '0;
            phase     <= 1'b0;
            OVERFLOW  <= 1'b0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            COUNT     <= count_next;
            phase     <= phase_next;
            OVERFLOW  <= OVERFLOW | drop;
            OUT_VALID <= (count_next != '0);
            OUT_DATA  <= head_next;
        end
    end

    // Storage is not reset; occupancy tracking makes stale words unobservable
    always_ff @(posedge CLK) begin
        if (RESET && push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: tb/tb_mbf_decim_fifo.sv
// Self-checking bench for mbf_decim_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mbf_decim_fifo;

    localparam int unsigned DW    = 13;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   x_in = '0;
    logic [DW-1:0]   y_in = '0;
    logic            ready = 1'b0;
    logic            out_valid;
    logic [2*DW-1:0] out_data;
    logic [AW:0]     count;
    logic            overflow;

    int passed = 0;
    int total  = 0;
    bit started = 1'b0;

    logic [2*DW-1:0] mq[$];
    bit              m_phase = 1'b0;
    bit              m_ovf = 1'b0;
    logic [2*DW-1:0] cap[$];

    mbf_decim_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .X_IN(x_in), .Y_IN(y_in),
        .OUT_READY(ready), .OUT_VALID(out_valid), .OUT_DATA(out_data),
        .COUNT(count), .OVERFLOW(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as a queue, pop before the capacity test
    initial begin
        bit pop, keep;
        forever begin
            @(posedge clk);
            if (!rst) begin
                mq.delete();
                m_phase = 1'b0;
                m_ovf = 1'b0;
            end else begin
                pop  = (mq.size() != 0) && ready;
                keep = in_valid && !m_phase;
                if (pop) void'(mq.pop_front());
                if (keep) begin
                    if (mq.size() < DEPTH) mq.push_back({x_in, y_in});
                    else m_ovf = 1'b1;
                end
                m_phase = in_valid ? !m_phase : 1'b0;
            end
            started = 1'b1;
        end
    end

    // Per-cycle comparison away from the active edge, and capture of popped words
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("out_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            check("count", 32'(count), 32'(mq.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (rst && out_valid && ready) cap.push_back(out_data);
        end
    end

    task automatic step(input logic v, input int x, input int y, input logic r);
        in_valid = v;
        x_in = DW'(x);
        y_in = DW'(y);
        ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, r);
    endtask

    initial begin
        // Reset held with valid input present
        rst = 1'b0;
        step(1'b1, 13'h1FFF, 0, 1'b1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        step(1'b1, 13'h1FFF, 0, 1'b1);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;

        // Decimation of a 6-pair burst
        cap.delete();
        for (int i = 1; i <= 6; i++) step(1'b1, i, 100 + i, 1'b1);
        idle(3, 1'b1);
        check("dec_n", 32'(cap.size()), 32'd3);
        if (cap.size() == 3) begin
            check("dec0", 32'(cap[0]), {6'd0, 13'd1, 13'd101});
            check("dec1", 32'(cap[1]), {6'd0, 13'd3, 13'd103});
            check("dec2", 32'(cap[2]), {6'd0, 13'd5, 13'd105});
        end

        // Burst restart
        cap.delete();
        for (int i = 1; i <= 3; i++) step(1'b1, i, 0, 1'b1);
        idle(1, 1'b1);
        for (int i = 4; i <= 5; i++) step(1'b1, i, 0, 1'b1);
        idle(3, 1'b1);
        check("rst_n", 32'(cap.size()), 32'd3);
        if (cap.size() == 3) begin
            check("restart0", 32'(cap[0][2*DW-1:DW]), 32'd1);
            check("restart1", 32'(cap[1][2*DW-1:DW]), 32'd3);
            check("restart2", 32'(cap[2][2*DW-1:DW]), 32'd4);
        end

        // Fill under backpressure, then overflow, then drain
        for (int i = 0; i < 16; i++) step(1'b1, i, 200 + i, 1'b0);
        idle(2, 1'b0);
        check("fill_count", 32'(count), 32'd8);
        check("fill_head", 32'(out_data), {6'd0, 13'd0, 13'd200});
        check("fill_ovf", 32'(overflow), 32'd0);
        step(1'b1, 100, 0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        step(1'b1, 101, 0, 1'b0);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_head", 32'(out_data), {6'd0, 13'd0, 13'd200});
        cap.delete();
        idle(10, 1'b1);
        check("drain_count", 32'(count), 32'd0);
        check("drain_ovf", 32'(overflow), 32'd1);
        check("drain_n", 32'(cap.size()), 32'd8);
        for (int i = 0; i < 8 && i < cap.size(); i++)
            check("drain_x", 32'(cap[i][2*DW-1:DW]), 32'(2 * i));

        // Full FIFO with simultaneous pop and kept sample
        rst = 1'b0;
        idle(1, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, i, 0, 1'b0);
        idle(1, 1'b0);
        cap.delete();
        step(1'b1, 77, 177, 1'b1);
        check("fp_count", 32'(count), 32'd8);
        check("fp_ovf", 32'(overflow), 32'd0);
        idle(12, 1'b1);
        check("fp_n", 32'(cap.size()), 32'd9);
        if (cap.size() == 9) begin
            check("fp_head", 32'(cap[0][2*DW-1:DW]), 32'd0);
            check("fp_77", 32'(cap[8]), {6'd0, 13'd77, 13'd177});
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            step(1'($urandom_range(0, 9) < 7), int'($urandom_range(0, 8191)),
                 int'($urandom_range(0, 8191)), 1'($urandom_range(0, 9) < 4));
        end
        rst = 1'b1;
        idle(12, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
